// File: rtl/divisor_pkg.sv
// Shared types and constants for the iterative restoring divider.
package divisor_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PREP   = 3'd1,
        OPER   = 3'd2,
        FIN    = 3'd3,
        ESPERA = 3'd4
    } estado_t;

endpackage

// File: rtl/divisor_paso.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor, keep the difference if it did not
// go negative, and shift the resulting quotient bit in at the LSB.
module divisor_paso #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] den_i,
    output logic [WIDTH:0]   rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0] rem_shift;
    logic [WIDTH:0] trial;
    logic           q_bit;

    // The partial remainder is always below the divisor, so after the shift
    // it fits in WIDTH+1 bits and the trial MSB is a valid borrow indicator.
    always_comb begin
        rem_shift = {rem_i[WIDTH-1:0], quo_i[WIDTH-1]};
        trial     = rem_shift - {1'b0, den_i};
        q_bit     = ~trial[WIDTH];
        rem_o     = q_bit ? trial : rem_shift;
        quo_o     = {quo_i[WIDTH-2:0], q_bit};
    end

endmodule

// File: rtl/divisor_algoritmico_param.sv
// Iterative signed/unsigned restoring divider, one quotient bit per cycle.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | waiting for Start; operands latched when it is seen
// PREP   | divide-by-zero check, operand magnitudes, sign capture
// OPER   | WIDTH restoring steps, MSB first
// FIN    | sign correction, results/flag written, Done pulsed
// ESPERA | waiting for Start to go low so a held Start cannot retrigger
module divisor_algoritmico_param
    import divisor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             CLK,
    input  logic             RSTa,
    input  logic             Start,
    input  logic             Signed_mode,
    input  logic [WIDTH-1:0] Num,
    input  logic [WIDTH-1:0] Den,
    output logic [WIDTH-1:0] Coc,
    output logic [WIDTH-1:0] Res,
    output logic             Done,
    output logic             Busy,
    output logic             Div_cero
);

    localparam int CW = $clog2(WIDTH + 1);

    estado_t          estado_q, estado_d;
    logic [WIDTH-1:0] num_q, num_d;
    logic [WIDTH-1:0] den_q, den_d;
    logic             modo_q, modo_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sgn_coc_q, sgn_coc_d;
    logic             sgn_res_q, sgn_res_d;
    logic [WIDTH-1:0] coc_q, coc_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             dz_q, dz_d;

    logic [WIDTH:0]   paso_rem;
    logic [WIDTH-1:0] paso_quo;
    logic [WIDTH-1:0] rem_lo;

    assign rem_lo = rem_q[WIDTH-1:0];

    divisor_paso #(
        .WIDTH (WIDTH)
    ) u_paso (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .den_i (den_q),
        .rem_o (paso_rem),
        .quo_o (paso_quo)
    );

    // Next-state and datapath update; every register holds unless its state acts.
    always_comb begin
        estado_d  = estado_q;
        num_d     = num_q;
        den_d     = den_q;
        modo_d    = modo_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        cnt_d     = cnt_q;
        sgn_coc_d = sgn_coc_q;
        sgn_res_d = sgn_res_q;
        coc_d     = coc_q;
        res_d     = res_q;
        done_d    = 1'b0;
        busy_d    = busy_q;
        dz_d      = dz_q;

        case (estado_q)
            IDLE: begin
                if (Start) begin
                    num_d    = Num;
                    den_d    = Den;
                    modo_d   = Signed_mode;
                    busy_d   = 1'b1;
                    estado_d = PREP;
                end
            end

            PREP: begin
                if (den_q == '0) begin
                    estado_d = FIN;
                end else begin
                    // The dividend is loaded into the quotient register and
                    // shifted out MSB first as quotient bits shift in.
                    quo_d     = (modo_q && num_q[WIDTH-1]) ? -num_q : num_q;
                    den_d     = (modo_q && den_q[WIDTH-1]) ? -den_q : den_q;
                    rem_d     = '0;
                    sgn_coc_d = modo_q & (num_q[WIDTH-1] ^ den_q[WIDTH-1]);
                    sgn_res_d = modo_q & num_q[WIDTH-1];
                    cnt_d     = CW'(WIDTH);
                    estado_d  = OPER;
                end
            end

            OPER: begin
                rem_d = paso_rem;
                quo_d = paso_quo;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    estado_d = FIN;
                end
            end

            FIN: begin
                if (den_q == '0) begin
                    coc_d = '0;
                    res_d = '0;
                    dz_d  = 1'b1;
                end else begin
                    coc_d = sgn_coc_q ? -quo_q : quo_q;
                    res_d = sgn_res_q ? -rem_lo : rem_lo;
                    dz_d  = 1'b0;
                end
                done_d   = 1'b1;
                busy_d   = 1'b0;
                estado_d = ESPERA;
            end

            ESPERA: begin
                if (!Start) begin
                    estado_d = IDLE;
                end
            end

            default: begin
                estado_d = IDLE;
            end
        endcase
    end

    // Single register bank with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RSTa) begin
            estado_q  <= IDLE;
            num_q     <= '0;
            den_q     <= '0;
            modo_q    <= 1'b0;
            rem_q     <= '0;
            quo_q     <= '0;
            cnt_q     <= '0;
            sgn_coc_q <= 1'b0;
            sgn_res_q <= 1'b0;
            coc_q     <= '0;
            res_q     <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            num_q     <= num_d;
            den_q     <= den_d;
            modo_q    <= modo_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            cnt_q     <= cnt_d;
            sgn_coc_q <= sgn_coc_d;
            sgn_res_q <= sgn_res_d;
            coc_q     <= coc_d;
            res_q     <= res_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            dz_q      <= dz_d;
        end
    end

    assign Coc      = coc_q;
    assign Res      = res_q;
    assign Done     = done_q;
    assign Busy     = busy_q;
    assign Div_cero = dz_q;

endmodule

// File: tb/tb_divisor_algoritmico_param.sv
// Directed bench for the iterative divider: 32-bit and 8-bit instances.
module tb_divisor_algoritmico_param;

    logic        CLK;
    logic        RSTa;

    logic        Start32, Sm32, Done32, Busy32, Dz32;
    logic [31:0] Num32, Den32, Coc32, Res32;

    logic        Start8, Sm8, Done8, Busy8, Dz8;
    logic [7:0]  Num8, Den8, Coc8, Res8;

    int vectors;
    int miscompares;

    divisor_algoritmico_param #(.WIDTH(32)) dut32 (
        .CLK         (CLK),
        .RSTa        (RSTa),
        .Start       (Start32),
        .Signed_mode (Sm32),
        .Num         (Num32),
        .Den         (Den32),
        .Coc         (Coc32),
        .Res         (Res32),
        .Done        (Done32),
        .Busy        (Busy32),
        .Div_cero    (Dz32)
    );

    divisor_algoritmico_param #(.WIDTH(8)) dut8 (
        .CLK         (CLK),
        .RSTa        (RSTa),
        .Start       (Start8),
        .Signed_mode (Sm8),
        .Num         (Num8),
        .Den         (Den8),
        .Coc         (Coc8),
        .Res         (Res8),
        .Done        (Done8),
        .Busy        (Busy8),
        .Div_cero    (Dz8)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not reach its end");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic op32(input string tag, input logic sm, input logic [31:0] n,
                        input logic [31:0] d, input logic [31:0] ec, input logic [31:0] er,
                        input logic edz, input int elat);
        int  lat;
        bit  got;
        @(negedge CLK);
        Sm32 = sm; Num32 = n; Den32 = d; Start32 = 1'b1;
        @(posedge CLK);
        #1;
        Start32 = 1'b0;
        chk({tag, "_busy"}, 64'(Busy32), 64'd1);
        lat = 0; got = 0;
        while (!got && lat < 200) begin
            @(posedge CLK);
            lat++;
            #1;
            if (Done32) got = 1;
        end
        chk({tag, "_latency"}, 64'(lat), 64'(elat));
        chk({tag, "_coc"}, 64'(Coc32), 64'(ec));
        chk({tag, "_res"}, 64'(Res32), 64'(er));
        chk({tag, "_divcero"}, 64'(Dz32), 64'(edz));
        chk({tag, "_busy_at_done"}, 64'(Busy32), 64'd0);
        @(posedge CLK);
        #1;
        chk({tag, "_done_one_cycle"}, 64'(Done32), 64'd0);
    endtask

    task automatic op8(input string tag, input logic sm, input logic [7:0] n,
                       input logic [7:0] d, input logic [7:0] ec, input logic [7:0] er,
                       input int elat);
        int  lat;
        bit  got;
        @(negedge CLK);
        Sm8 = sm; Num8 = n; Den8 = d; Start8 = 1'b1;
        @(posedge CLK);
        #1;
        Start8 = 1'b0;
        lat = 0; got = 0;
        while (!got && lat < 100) begin
            @(posedge CLK);
            lat++;
            #1;
            if (Done8) got = 1;
        end
        chk({tag, "_latency"}, 64'(lat), 64'(elat));
        chk({tag, "_coc"}, 64'(Coc8), 64'(ec));
        chk({tag, "_res"}, 64'(Res8), 64'(er));
        chk({tag, "_divcero"}, 64'(Dz8), 64'd0);
        @(posedge CLK);
        #1;
        chk({tag, "_done_one_cycle"}, 64'(Done8), 64'd0);
    endtask

    initial begin
        int pulses;

        vectors = 0;
        miscompares = 0;
        RSTa = 1'b0;
        Start32 = 1'b0; Sm32 = 1'b0; Num32 = '0; Den32 = '0;
        Start8  = 1'b0; Sm8  = 1'b0; Num8  = '0; Den8  = '0;

        repeat (3) @(posedge CLK);
        #1;
        chk("rst_coc",  64'(Coc32),  64'd0);
        chk("rst_res",  64'(Res32),  64'd0);
        chk("rst_done", 64'(Done32), 64'd0);
        chk("rst_busy", 64'(Busy32), 64'd0);
        chk("rst_dz",   64'(Dz32),   64'd0);
        chk("rst8_coc", 64'(Coc8),   64'd0);
        @(negedge CLK);
        RSTa = 1'b1;

        // Signed basics, truncation toward zero, remainder follows Num.
        op32("s50_2",   1'b1, 32'd50,  32'd2,   32'd25,   32'd0,   1'b0, 34);
        op32("s17_m4",  1'b1, 32'd17,  -32'sd4, -32'sd4,  32'd1,   1'b0, 34);
        op32("sm42_8",  1'b1, -32'sd42, 32'd8,  -32'sd5,  -32'sd2, 1'b0, 34);
        op32("sm9_m6",  1'b1, -32'sd9, -32'sd6, 32'd1,    -32'sd3, 1'b0, 34);

        // Divide by zero then a clean operation clears the flag.
        op32("s7_0",    1'b1, 32'd7, 32'd0, 32'd0, 32'd0, 1'b1, 2);
        op32("s7_3",    1'b1, 32'd7, 32'd3, 32'd2, 32'd1, 1'b0, 34);

        // Same bit pattern, unsigned vs signed.
        op32("uffff_2", 1'b0, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, 32'd1, 1'b0, 34);
        op32("sffff_2", 1'b1, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'hFFFF_FFFF, 1'b0, 34);
        op32("u8000_ffff", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 34);

        // Signed overflow wraps without a flag.
        op32("s_ovf",   1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 34);

        // Narrow instance.
        op8("w8_m128_7", 1'b1, 8'h80, 8'd7, 8'hEE, 8'hFE, 10);

        // Held-high Start with a Num change during Busy.
        @(negedge CLK);
        Sm32 = 1'b1; Num32 = 32'd50; Den32 = 32'd2; Start32 = 1'b1;
        pulses = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge CLK);
            #1;
            if (Done32) pulses++;
            if (i == 5) Num32 = 32'd999;
        end
        chk("hold_pulses", 64'(pulses), 64'd1);
        chk("hold_coc", 64'(Coc32), 64'd25);
        chk("hold_res", 64'(Res32), 64'd0);
        @(negedge CLK);
        Start32 = 1'b0;
        repeat (2) @(posedge CLK);

        // Reset at cycle 10 of an operation aborts it.
        @(negedge CLK);
        Sm32 = 1'b1; Num32 = 32'd100; Den32 = 32'd3; Start32 = 1'b1;
        @(posedge CLK);
        #1;
        Start32 = 1'b0;
        repeat (9) @(posedge CLK);
        @(negedge CLK);
        RSTa = 1'b0;
        @(posedge CLK);
        #1;
        chk("abort_coc",  64'(Coc32),  64'd0);
        chk("abort_res",  64'(Res32),  64'd0);
        chk("abort_done", 64'(Done32), 64'd0);
        chk("abort_busy", 64'(Busy32), 64'd0);
        chk("abort_dz",   64'(Dz32),   64'd0);
        @(negedge CLK);
        RSTa = 1'b1;
        pulses = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge CLK);
            #1;
            if (Done32) pulses++;
        end
        chk("abort_no_done", 64'(pulses), 64'd0);
        op32("post_rst_50_2", 1'b1, 32'd50, 32'd2, 32'd25, 32'd0, 1'b0, 34);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
